// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Sends one command byte to the keyboard over the shared open-drain
// clock/data pair: inhibit, request-to-send, then shift out 8 data bits,
// odd parity and stop on device clock falls, and check the device ack.
// busy tells the neighbouring receiver to ignore the lines meanwhile.
// Optional watchdog: define PS2_HOST_TX_TIMEOUT_EN to abort frames that
// do not complete within TIMEOUT_CYCLES of releasing the clock.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10_000,
    parameter int TIMEOUT_CYCLES = 1_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SEND,
        ST_WAIT_IDLE
    } state_t;

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       clk_sync_q, clk_sync_d;
    logic [1:0]       data_sync_q, data_sync_d;
    logic             clk_prev_q, clk_prev_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [3:0]       edge_cnt_q, edge_cnt_d;
    logic             nack_q, nack_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             ack_err_q, ack_err_d;

    logic             clk_s;
    logic             data_s;
    logic             clk_fall;
    logic             timeout;

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    // Watchdog: runs from clock release until the frame is finished.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == ST_RTS) begin
            wd_cnt_d = '0;
        end else if (state_q == ST_SEND || state_q == ST_WAIT_IDLE) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    assign timeout = (state_q == ST_SEND || state_q == ST_WAIT_IDLE) && (wd_cnt_q == WD_LAST);

    // Watchdog counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign clk_s    = clk_sync_q[1];
    assign data_s   = data_sync_q[1];
    assign clk_fall = clk_prev_q & ~clk_s;

    assign tx_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign ack_err     = ack_err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

    // State register plus every datapath and output flop; idle lines read high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            inh_cnt_q   <= '0;
            edge_cnt_q  <= '0;
            nack_q      <= 1'b0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            done_q      <= 1'b0;
            ack_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            inh_cnt_q   <= inh_cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            nack_q      <= nack_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            done_q      <= done_d;
            ack_err_q   <= ack_err_d;
        end
    end

    // Next state: frame sequencing, inhibit timer, edge counting and ack capture.
    always_comb begin
        state_d     = state_q;
        clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
        data_sync_d = {data_sync_q[0], ps2_data_in};
        clk_prev_d  = clk_sync_q[1];
        shift_d     = shift_q;
        parity_d    = parity_q;
        inh_cnt_d   = inh_cnt_q;
        edge_cnt_d  = edge_cnt_q;
        nack_d      = nack_q;

        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    shift_d   = tx_data;
                    parity_d  = ~^tx_data;
                    inh_cnt_d = '0;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    state_d = ST_RTS;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            ST_RTS: begin
                edge_cnt_d = '0;
                nack_d     = 1'b0;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (clk_fall) begin
                    if (edge_cnt_q != 4'hF) begin
                        edge_cnt_d = edge_cnt_q + 1'b1;
                    end
                    if (edge_cnt_q == 4'd10) begin
                        nack_d  = data_s;
                        state_d = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (timeout) begin
            state_d = ST_IDLE;
        end
    end

    // Outputs: line enables, done pulse and ack status, registered from next state.
    always_comb begin
        clk_oe_d  = (state_d == ST_INHIBIT) || (state_d == ST_RTS);
        data_oe_d = 1'b0;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;

        if (state_d == ST_RTS) begin
            data_oe_d = 1'b1;
        end else if (state_d == ST_SEND) begin
            if (state_q == ST_RTS) begin
                data_oe_d = 1'b1;
            end else if (clk_fall) begin
                if (edge_cnt_q < 4'd8) begin
                    data_oe_d = ~shift_q[edge_cnt_q[2:0]];
                end else if (edge_cnt_q == 4'd8) begin
                    data_oe_d = ~parity_q;
                end else begin
                    data_oe_d = 1'b0;
                end
            end else begin
                data_oe_d = data_oe_q;
            end
        end

        if (timeout) begin
            done_d    = 1'b1;
            ack_err_d = 1'b1;
        end else if (state_q == ST_WAIT_IDLE && state_d == ST_IDLE) begin
            done_d    = 1'b1;
            ack_err_d = nack_q;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a PS/2 device model
// that clocks the frame, samples the bits and optionally acks.
module tb_ps2_host_tx;

    localparam int INHIBIT = 20;
    localparam int TIMEOUT = 5000;
    // With the watchdog built in, the device clock is sped up so a full
    // frame fits inside the 5000-cycle watchdog window.
`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int PHASE = 200;
`else
    localparam int PHASE = 500;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    int         assertions = 0;
    int         failures = 0;
    int         done_count = 0;
    logic       done_ack_err = 1'b0;
    logic       done_ready = 1'b0;
    logic       done_clk_oe = 1'b0;
    logic       done_data_oe = 1'b0;

    int          n_oe;
    int          n_hits;
    int          pos;
    int          w;
    int          start;
    logic [10:0] bits;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    // Open-drain wired-AND of host enables and device drive.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    // 10 ns system clock.
    always #5 clk = ~clk;

    // Record every done pulse and the outputs seen alongside it.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count   <= done_count + 1;
            done_ack_err <= ack_err;
            done_ready   <= tx_ready;
            done_clk_oe  <= ps2_clk_oe;
            done_data_oe <= ps2_data_oe;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    // Count cycles with clk_oe high and where data_oe was high among them.
    task automatic measureInhibit(output int oe_cycles, output int data_hits, output int data_pos);
        oe_cycles = 0;
        data_hits = 0;
        data_pos  = 0;
        while (ps2_clk_oe === 1'b1 && oe_cycles < 1000) begin
            oe_cycles++;
            if (ps2_data_oe === 1'b1) begin
                data_hits++;
                data_pos = oe_cycles;
            end
            tick();
        end
    endtask

    // Device model: clocks up to 11 edges, samples on rising edges, optional ack.
    task automatic deviceFrame(input logic do_ack, input int hold, input int stop_at, output logic [10:0] sampled);
        int guard;
        sampled = '0;
        guard = 0;
        while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && guard < 2000) begin
            tick();
            guard++;
        end
        checkOutput("dev_rts_seen", {30'd0, ps2_clk_in, ps2_data_in}, 32'd2);
        repeat (50) tick();
        sampled[0] = ps2_data_in;
        for (int i = 1; i <= 11; i++) begin
            dev_clk = 1'b0;
            if (i == stop_at) return;
            repeat (PHASE) tick();
            dev_clk = 1'b1;
            if (i <= 10) sampled[i] = ps2_data_in;
            if (i == 10 && do_ack) begin
                repeat (PHASE / 2) tick();
                dev_data = 1'b0;
                repeat (PHASE - PHASE / 2) tick();
            end else if (i < 11) begin
                repeat (PHASE) tick();
            end
        end
        repeat (hold) tick();
        dev_data = 1'b1;
    endtask

    task automatic waitDone(input int limit, output int waited);
        int base;
        base   = done_count;
        waited = 0;
        while (done_count == base && waited < limit) begin
            tick();
            waited++;
        end
    endtask

    // Directed sequence.
    initial begin
        rst = 1'b1;
        repeat (3) tick();
        checkOutput("rst_clk_oe", ps2_clk_oe, 0);
        checkOutput("rst_data_oe", ps2_data_oe, 0);
        checkOutput("rst_tx_ready", tx_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_ack_err", ack_err, 0);
        rst = 1'b0;
        repeat (3) tick();

        $display("[TB] Test 1: send 0xED with ack");
        applyStimulus(8'hED);
        checkOutput("t1_accept_clk_oe", ps2_clk_oe, 1);
        checkOutput("t1_busy", busy, 1);
        checkOutput("t1_ready_low", tx_ready, 0);
        measureInhibit(n_oe, n_hits, pos);
        start = done_count;
        deviceFrame(1'b1, 0, 12, bits);
        waitDone(50, w);
        checkOutput("t1_bits", bits, 11'h7DA);
        checkOutput("t1_done_count", done_count - start, 1);
        checkOutput("t1_ack_err", done_ack_err, 0);
        checkOutput("t1_ready_at_done", done_ready, 1);
        tick();
        checkOutput("t1_ready_after", tx_ready, 1);

        $display("[TB] Test 2: inhibit timing and parity");
        applyStimulus(8'h01);
        measureInhibit(n_oe, n_hits, pos);
        checkOutput("t2_clk_oe_cycles", n_oe, 21);
        checkOutput("t2_data_oe_hits", n_hits, 1);
        checkOutput("t2_data_oe_pos", pos, 21);
        checkOutput("t2_start_held", ps2_data_oe, 1);
        start = done_count;
        deviceFrame(1'b1, 0, 12, bits);
        waitDone(50, w);
        checkOutput("t2_bits_01", bits, 11'h402);
        checkOutput("t2_parity_01", bits[9], 0);
        checkOutput("t2_done_01", done_count - start, 1);
        tick();
        applyStimulus(8'hFF);
        measureInhibit(n_oe, n_hits, pos);
        start = done_count;
        deviceFrame(1'b1, 0, 12, bits);
        waitDone(50, w);
        checkOutput("t2_bits_ff", bits, 11'h7FE);
        checkOutput("t2_parity_ff", bits[9], 1);
        checkOutput("t2_ack_err_ff", done_ack_err, 0);
        tick();

        $display("[TB] Test 3: missing ack");
        applyStimulus(8'hED);
        measureInhibit(n_oe, n_hits, pos);
        start = done_count;
        deviceFrame(1'b0, 0, 12, bits);
        waitDone(50, w);
        checkOutput("t3_done", done_count - start, 1);
        checkOutput("t3_ack_err", done_ack_err, 1);
        checkOutput("t3_clk_oe", done_clk_oe, 0);
        checkOutput("t3_data_oe", done_data_oe, 0);
        tick();

        $display("[TB] Test 5: tx_valid ignored in SEND, reset mid-frame");
        applyStimulus(8'h0F);
        measureInhibit(n_oe, n_hits, pos);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        start = done_count;
        deviceFrame(1'b1, 0, 5, bits);
        checkOutput("t5_ready_ignored", tx_ready, 0);
        checkOutput("t5_bits_first_byte", bits[4:1], 4'hF);
        repeat (10) tick();
        checkOutput("t5_data_oe_before_rst", ps2_data_oe, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("t5_clk_oe_async", ps2_clk_oe, 0);
        checkOutput("t5_data_oe_async", ps2_data_oe, 0);
        tx_valid = 1'b0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (5) tick();
        rst = 1'b0;
        repeat (5) tick();
        checkOutput("t5_no_done", done_count - start, 0);
        checkOutput("t5_ready_after_rst", tx_ready, 1);
        checkOutput("t5_busy_after_rst", busy, 0);

        $display("[TB] Test 6: device holds data low after ack");
        applyStimulus(8'hF0);
        measureInhibit(n_oe, n_hits, pos);
        start = done_count;
        deviceFrame(1'b1, 100, 12, bits);
        checkOutput("t6_bits", bits, 11'h7E0);
        checkOutput("t6_no_done_while_held", done_count - start, 0);
        checkOutput("t6_busy_while_held", busy, 1);
        waitDone(20, w);
        checkOutput("t6_done_latency", w, 3);
        checkOutput("t6_ack_err", done_ack_err, 0);
        repeat (30) tick();
        checkOutput("t6_single_done", done_count - start, 1);

        $display("[TB] Test 4: device never clocks");
        applyStimulus(8'hAA);
        measureInhibit(n_oe, n_hits, pos);
        start = done_count;
`ifdef PS2_HOST_TX_TIMEOUT_EN
        waitDone(6000, w);
        checkOutput("t4_timeout_cycles", w, TIMEOUT);
        checkOutput("t4_done", done_count - start, 1);
        checkOutput("t4_ack_err", done_ack_err, 1);
        checkOutput("t4_clk_oe", done_clk_oe, 0);
        checkOutput("t4_data_oe", done_data_oe, 0);
        tick();
        checkOutput("t4_ready_after", tx_ready, 1);
`else
        waitDone(6000, w);
        checkOutput("t4_no_timeout_done", done_count - start, 0);
        checkOutput("t4_still_busy", busy, 1);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checkOutput("t4_ready_after_rst", tx_ready, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
